// File: rtl/exec_alu_branch.sv
// Execute stage for lx32: an RV32I integer ALU and a branch-condition evaluator
// that share one operand pair. All results are registered with one cycle of latency.
module exec_alu_branch #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [3:0]       alu_control,
    input  logic             is_branch,
    input  logic [2:0]       branch_op,
    output logic [WIDTH-1:0] alu_result,
    output logic             branch_taken,
    output logic             valid_out
);

    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_PASS_B = 4'd10
    } alu_op_e;

    typedef enum logic [2:0] {
        BR_BEQ  = 3'd0,
        BR_BNE  = 3'd1,
        BR_BLT  = 3'd4,
        BR_BGE  = 3'd5,
        BR_BLTU = 3'd6,
        BR_BGEU = 3'd7
    } branch_op_e;

    logic [WIDTH-1:0] result_d, result_q;
    logic             taken_d, taken_q;
    logic             valid_q;

    logic [SHW-1:0]   shamt;
    logic             eq;
    logic             lt_s;
    logic             lt_u;
    logic             cond;

    // One set of comparators serves both the SLT/SLTU ops and the branch unit.
    assign shamt = src_b[SHW-1:0];
    assign eq    = (src_a == src_b);
    assign lt_s  = ($signed(src_a) < $signed(src_b));
    assign lt_u  = (src_a < src_b);

    always_comb begin
        result_d = '0;
        case (alu_op_e'(alu_control))
            ALU_ADD:    result_d = src_a + src_b;
            ALU_SUB:    result_d = src_a - src_b;
            ALU_SLL:    result_d = src_a << shamt;
            ALU_SLT:    result_d = {{(WIDTH-1){1'b0}}, lt_s};
            ALU_SLTU:   result_d = {{(WIDTH-1){1'b0}}, lt_u};
            ALU_XOR:    result_d = src_a ^ src_b;
            ALU_SRL:    result_d = src_a >> shamt;
            ALU_SRA:    result_d = $unsigned($signed(src_a) >>> shamt);
            ALU_OR:     result_d = src_a | src_b;
            ALU_AND:    result_d = src_a & src_b;
            ALU_PASS_B: result_d = src_b;
            default:    result_d = '0;
        endcase
    end

    always_comb begin
        cond = 1'b0;
        case (branch_op_e'(branch_op))
            BR_BEQ:  cond = eq;
            BR_BNE:  cond = !eq;
            BR_BLT:  cond = lt_s;
            BR_BGE:  cond = !lt_s;
            BR_BLTU: cond = lt_u;
            BR_BGEU: cond = !lt_u;
            default: cond = 1'b0;
        endcase
        taken_d = is_branch && cond;
    end

    // Data registers hold across idle cycles so undriven operands never leak out.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
            taken_q  <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= valid_in;
            if (valid_in) begin
                result_q <= result_d;
                taken_q  <= taken_d;
            end
        end
    end

    assign alu_result   = result_q;
    assign branch_taken = taken_q;
    assign valid_out    = valid_q;

endmodule

// File: tb/tb_exec_alu_branch.sv
// Self-checking bench for exec_alu_branch: directed corner cases plus a
// randomized regression scored against an arithmetic reference model.
module tb_exec_alu_branch;

    logic        clk;
    logic        rst;
    logic        valid_in;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [3:0]  alu_control;
    logic        is_branch;
    logic [2:0]  branch_op;
    logic [31:0] alu_result;
    logic        branch_taken;
    logic        valid_out;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_res = '0;
    logic        m_bt  = 1'b0;
    logic        m_v   = 1'b0;

    exec_alu_branch #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_in     (valid_in),
        .src_a        (src_a),
        .src_b        (src_b),
        .alu_control  (alu_control),
        .is_branch    (is_branch),
        .branch_op    (branch_op),
        .alu_result   (alu_result),
        .branch_taken (branch_taken),
        .valid_out    (valid_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pow2(input int unsigned n);
        logic [31:0] p = 32'd1;
        for (int i = 0; i < int'(n); i++) p = p * 32'd2;
        return p;
    endfunction

    // Reference ALU written from the instruction semantics using plain arithmetic.
    function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
        int unsigned sh  = b % 32;
        longint      sa  = longint'($signed(a));
        longint      sb  = longint'($signed(b));
        longint      ua  = longint'({32'd0, a});
        longint      ub  = longint'({32'd0, b});
        case (op)
            0:  return 32'(ua + ub);
            1:  return 32'(ua - ub);
            2:  return 32'(ua * longint'(pow2(sh)));
            3:  return (sa < sb) ? 32'd1 : 32'd0;
            4:  return (ua < ub) ? 32'd1 : 32'd0;
            5:  return a ^ b;
            6:  return a / pow2(sh);
            7:  return a[31] ? ~((~a) / pow2(sh)) : a / pow2(sh);
            8:  return a | b;
            9:  return a & b;
            10: return b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic ref_cond(input int bop, input logic [31:0] a, input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ua = longint'({32'd0, a});
        longint ub = longint'({32'd0, b});
        case (bop)
            0: return ua == ub;
            1: return ua != ub;
            4: return sa < sb;
            5: return sa >= sb;
            6: return ua < ub;
            7: return ua >= ub;
            default: return 1'b0;
        endcase
    endfunction

    // Drive one cycle of inputs, clock it in, advance the model and compare.
    task automatic step(input logic r, input logic v, input logic [31:0] a, input logic [31:0] b,
                        input int op, input logic isb, input int bop);
        @(negedge clk);
        rst         = r;
        valid_in    = v;
        src_a       = a;
        src_b       = b;
        alu_control = 4'(op);
        is_branch   = isb;
        branch_op   = 3'(bop);
        @(posedge clk);
        if (r) begin
            m_res = '0;
            m_bt  = 1'b0;
            m_v   = 1'b0;
        end else begin
            m_v = v;
            if (v) begin
                m_res = ref_alu(op, a, b);
                m_bt  = isb && ref_cond(bop, a, b);
            end
        end
        #1;
        chk("model_result", alu_result, m_res);
        chk("model_taken", {31'd0, branch_taken}, {31'd0, m_bt});
        chk("model_valid", {31'd0, valid_out}, {31'd0, m_v});
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0: return 32'h8000_0000;
            1: return 32'h7FFF_FFFF;
            2: return 32'hFFFF_FFFF;
            3: return 32'(($urandom_range(0, 40)));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst = 1'b1; valid_in = 1'b0; src_a = '0; src_b = '0;
        alu_control = '0; is_branch = 1'b0; branch_op = '0;

        // Reset overrides valid_in
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b1, $urandom, $urandom, int'($urandom_range(0, 15)), 1'b1, int'($urandom_range(0, 7)));
            chk("rst_result", alu_result, 32'h0);
            chk("rst_valid", {31'd0, valid_out}, 32'd0);
            chk("rst_taken", {31'd0, branch_taken}, 32'd0);
        end
        step(1'b0, 1'b1, 32'd5, 32'd7, 0, 1'b0, 0);
        chk("add_first", alu_result, 32'h0000_000C);
        chk("add_first_valid", {31'd0, valid_out}, 32'd1);

        step(1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1, 0, 1'b0, 0);  chk("add_wrap", alu_result, 32'h0);
        step(1'b0, 1'b1, 32'd0, 32'd1, 1, 1'b0, 0);           chk("sub_wrap", alu_result, 32'hFFFF_FFFF);
        step(1'b0, 1'b1, 32'hF0F0_F0F0, 32'hFFFF_0000, 5, 1'b0, 0); chk("xor", alu_result, 32'h0F0F_F0F0);
        step(1'b0, 1'b1, 32'hF0F0_F0F0, 32'hFFFF_0000, 9, 1'b0, 0); chk("and", alu_result, 32'hF0F0_0000);
        step(1'b0, 1'b1, 32'hF0F0_F0F0, 32'hFFFF_0000, 8, 1'b0, 0); chk("or", alu_result, 32'hFFFF_F0F0);
        step(1'b0, 1'b1, 32'hDEAD_BEEF, 32'h1234_5000, 10, 1'b0, 0); chk("pass_b", alu_result, 32'h1234_5000);
        step(1'b0, 1'b1, 32'hDEAD_BEEF, 32'h1234_5000, 13, 1'b0, 0); chk("op13", alu_result, 32'h0);

        step(1'b0, 1'b1, 32'h8000_0001, 32'd4, 2, 1'b0, 0);    chk("sll4", alu_result, 32'h0000_0010);
        step(1'b0, 1'b1, 32'h8000_0001, 32'd4, 6, 1'b0, 0);    chk("srl4", alu_result, 32'h0800_0000);
        step(1'b0, 1'b1, 32'h8000_0001, 32'd4, 7, 1'b0, 0);    chk("sra4", alu_result, 32'hF800_0000);
        step(1'b0, 1'b1, 32'h8000_0001, 32'h21, 7, 1'b0, 0);   chk("sra_b21", alu_result, 32'hC000_0000);
        step(1'b0, 1'b1, 32'h8000_0001, 32'd0, 2, 1'b0, 0);    chk("sll0", alu_result, 32'h8000_0001);
        step(1'b0, 1'b1, 32'h8000_0001, 32'd32, 6, 1'b0, 0);   chk("srl32", alu_result, 32'h8000_0001);
        step(1'b0, 1'b1, 32'h8000_0001, 32'd31, 2, 1'b0, 0);   chk("sll31", alu_result, 32'h8000_0000);

        step(1'b0, 1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 3, 1'b1, 4); chk("slt", alu_result, 32'd1);
        chk("blt", {31'd0, branch_taken}, 32'd1);
        step(1'b0, 1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 4, 1'b1, 5); chk("sltu", alu_result, 32'd0);
        chk("bge", {31'd0, branch_taken}, 32'd0);
        step(1'b0, 1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 0, 1'b1, 6); chk("bltu", {31'd0, branch_taken}, 32'd0);
        step(1'b0, 1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 0, 1'b1, 7); chk("bgeu", {31'd0, branch_taken}, 32'd1);
        step(1'b0, 1'b1, 32'h1234, 32'h1234, 0, 1'b1, 0);           chk("beq", {31'd0, branch_taken}, 32'd1);
        step(1'b0, 1'b1, 32'h1234, 32'h1234, 0, 1'b1, 1);           chk("bne", {31'd0, branch_taken}, 32'd0);
        step(1'b0, 1'b1, 32'h1234, 32'h1234, 0, 1'b0, 0);           chk("beq_gated", {31'd0, branch_taken}, 32'd0);
        step(1'b0, 1'b1, 32'h1234, 32'h1234, 0, 1'b1, 2);           chk("bop2", {31'd0, branch_taken}, 32'd0);
        step(1'b0, 1'b1, 32'h1234, 32'h1234, 0, 1'b1, 3);           chk("bop3", {31'd0, branch_taken}, 32'd0);

        // Hold on idle: result and taken keep the last accepted values
        step(1'b0, 1'b1, 32'h10, 32'h10, 0, 1'b1, 0);
        step(1'b0, 1'b0, 32'hFFFF_FFFF, 32'h1, 1, 1'b0, 1);
        chk("hold_valid", {31'd0, valid_out}, 32'd0);
        chk("hold_result", alu_result, 32'h20);
        chk("hold_taken", {31'd0, branch_taken}, 32'd1);

        // Mid-stream reset clears outputs on that edge
        step(1'b1, 1'b1, 32'h3, 32'h4, 0, 1'b1, 0);
        chk("mid_rst", alu_result, 32'h0);

        for (int i = 0; i < 1200; i++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 8),
                 rand_operand(), rand_operand(), int'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
